rv_iret_trace_buf: RTL and testbench

//  Multi-channel instruction-retirement trace buffer. Accepts up to NRET retirement records per cycle
//  (addr/insn/ires/fres/iret per channel, program order = ascending channel index). Compacts valid

---
 rtl/rv_iret_trace_buf_pkg.sv | 21 ++
 rtl/rv_iret_trace_buf_if.sv | 39 +++
 rtl/rv_iret_trace_buf_compact.sv | 23 ++
 rtl/rv_iret_trace_buf.sv | 137 +++++++++++++
 tb/tb_rv_iret_trace_buf.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_iret_trace_buf_pkg.sv
// Shared types and helpers for the instruction-retirement trace buffer.
package rv_iret_trace_pkg;

  localparam int DROP_CNT_W = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] insn;
    logic [31:0] ires;
    logic [31:0] fres;
    logic [31:0] seq;
  } trace_entry_t;

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/rv_iret_trace_buf_if.sv
// Retire-side inputs and sink-side valid/ready outputs of the trace buffer.
// drop_cnt is present only when RV_IRET_TRACE_DROP_CNT_EN is defined.
interface rv_iret_trace_buf_if #(
  parameter int XLEN = 32,
  parameter int FLEN = 32,
  parameter int NRET = 2,
  parameter int SEQW = 32
);
  logic                 flush;
  logic [NRET-1:0]      in_iret;
  logic [NRET*XLEN-1:0] in_addr;
  logic [NRET*32-1:0]   in_insn;
  logic [NRET*XLEN-1:0] in_ires;
  logic [NRET*FLEN-1:0] in_fres;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_addr;
  logic [31:0]          out_insn;
  logic [XLEN-1:0]      out_ires;
  logic [FLEN-1:0]      out_fres;
  logic [SEQW-1:0]      out_seq;
  logic                 full;
  logic                 ovf;
`ifdef RV_IRET_TRACE_DROP_CNT_EN
  logic [rv_iret_trace_pkg::DROP_CNT_W-1:0] drop_cnt;

  modport master (output flush, in_iret, in_addr, in_insn, in_ires, in_fres, out_ready,
                  input out_valid, out_addr, out_insn, out_ires, out_fres, out_seq, full, ovf,
                  drop_cnt);
  modport slave  (input flush, in_iret, in_addr, in_insn, in_ires, in_fres, out_ready,
                  output out_valid, out_addr, out_insn, out_ires, out_fres, out_seq, full, ovf,
                  drop_cnt);
`else
  modport master (output flush, in_iret, in_addr, in_insn, in_ires, in_fres, out_ready,
                  input out_valid, out_addr, out_insn, out_ires, out_fres, out_seq, full, ovf);
  modport slave  (input flush, in_iret, in_addr, in_insn, in_ires, in_fres, out_ready,
                  output out_valid, out_addr, out_insn, out_ires, out_fres, out_seq, full, ovf);
`endif
endinterface

// File: rtl/rv_iret_trace_buf_compact.sv
// Maps each retire channel to its slot offset among the valid records of the group.
module rv_iret_trace_compact
  import rv_iret_trace_pkg::*;
#(
  parameter int NRET = 2
) (
  input  logic [NRET-1:0]      iret,
  output logic [NRET-1:0][3:0] offs,
  output logic [3:0]           npush
);

  always_comb begin
    logic [3:0] acc;
    acc = '0;
    offs = '0;
    for (int unsigned i = 0; i < NRET; i++) begin
      offs[i] = acc;
      acc = acc + {3'b000, iret[i]};
    end
    npush = popcount(8'(iret));
  end

endmodule

// File: rtl/rv_iret_trace_buf.sv
// Multi-channel retirement trace FIFO: compacts, sequence-tags and drains one record per cycle.
// Optional RV_IRET_TRACE_DROP_CNT_EN adds a saturating dropped-record counter (drop_cnt).
module rv_iret_trace_buf
  import rv_iret_trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int FLEN  = 32,
  parameter int NRET  = 2,
  parameter int DEPTH = 16,
  parameter int SEQW  = 32
) (
  input logic               clk,
  input logic               rst,
  rv_iret_trace_buf_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [SEQW-1:0] seq_q, seq_d;
  logic            ovf_q, ovf_d;

  logic [XLEN-1:0] mem_addr [DEPTH];
  logic [31:0]     mem_insn [DEPTH];
  logic [XLEN-1:0] mem_ires [DEPTH];
  logic [FLEN-1:0] mem_fres [DEPTH];
  logic [SEQW-1:0] mem_seq  [DEPTH];

  logic [NRET-1:0][3:0]    offs;
  logic [3:0]              npush;
  logic [NRET-1:0][AW-1:0] wr_idx;
  logic                    pop, accept;
  logic [CW:0]             free;

  rv_iret_trace_compact #(.NRET(NRET)) u_compact (
    .iret  (bus.in_iret),
    .offs  (offs),
    .npush (npush)
  );

  assign pop    = (count_q != '0) & bus.out_ready;
  // free counts the slot released by a same-cycle pop, so a full FIFO can still take a group
  assign free   = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pop);
  assign accept = 32'(npush) <= 32'(free);

`ifdef RV_IRET_TRACE_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_CNT_W:0]   drop_sum;
  assign drop_sum = {1'b0, drop_cnt_q} + (DROP_CNT_W+1)'(npush);
  assign bus.drop_cnt = drop_cnt_q;
`endif

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    seq_d    = seq_q + SEQW'(npush);
    ovf_d    = ovf_q;
`ifdef RV_IRET_TRACE_DROP_CNT_EN
    drop_cnt_d = drop_cnt_q;
`endif
    if (bus.flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
`ifdef RV_IRET_TRACE_DROP_CNT_EN
      drop_cnt_d = '0;
`endif
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (accept) begin
        wr_ptr_d = wr_ptr_q + AW'(npush);
        count_d  = count_q + CW'(npush) - CW'(pop);
      end else begin
        count_d = count_q - CW'(pop);
        ovf_d   = 1'b1;
`ifdef RV_IRET_TRACE_DROP_CNT_EN
        drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
`endif
      end
    end
  end

  always_comb begin
    wr_idx = '0;
    for (int unsigned i = 0; i < NRET; i++) wr_idx[i] = wr_ptr_q + AW'(offs[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      seq_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef RV_IRET_TRACE_DROP_CNT_EN
      drop_cnt_q <= '0;
`endif
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      seq_q    <= seq_d;
      ovf_q    <= ovf_d;
`ifdef RV_IRET_TRACE_DROP_CNT_EN
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!bus.flush && accept) begin
      for (int unsigned i = 0; i < NRET; i++) begin
        if (bus.in_iret[i]) begin
          mem_addr[wr_idx[i]] <= bus.in_addr[i*XLEN +: XLEN];
          mem_insn[wr_idx[i]] <= bus.in_insn[i*32 +: 32];
          mem_ires[wr_idx[i]] <= bus.in_ires[i*XLEN +: XLEN];
          mem_fres[wr_idx[i]] <= bus.in_fres[i*FLEN +: FLEN];
          mem_seq[wr_idx[i]]  <= seq_q + SEQW'(offs[i]);
        end
      end
    end
  end

  assign bus.out_valid = count_q != '0;
  assign bus.full      = count_q == CW'(DEPTH);
  assign bus.ovf       = ovf_q;
  assign bus.out_addr  = mem_addr[rd_ptr_q];
  assign bus.out_insn  = mem_insn[rd_ptr_q];
  assign bus.out_ires  = mem_ires[rd_ptr_q];
  assign bus.out_fres  = mem_fres[rd_ptr_q];
  assign bus.out_seq   = mem_seq[rd_ptr_q];

endmodule

// File: tb/tb_rv_iret_trace_buf.sv
// Self-checking bench for rv_iret_trace_buf: directed table, corner sequences, random vs queue model.
module tb_rv_iret_trace_buf;
  import rv_iret_trace_pkg::*;

  localparam int NRET  = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_iret_trace_buf_if #(.XLEN(32), .FLEN(32), .NRET(NRET), .SEQW(32)) bus ();

  rv_iret_trace_buf #(.XLEN(32), .FLEN(32), .NRET(NRET), .DEPTH(DEPTH), .SEQW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  trace_entry_t mq[$];
  logic [31:0]  mseq;
  logic         movf;
  int unsigned  mdc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic model_reset();
    mq.delete();
    mseq = '0;
    movf = 1'b0;
    mdc  = 0;
  endtask

  task automatic check_model();
    chk("m_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
    chk("m_full", 64'(bus.full), 64'(mq.size() == DEPTH));
    chk("m_ovf", 64'(bus.ovf), 64'(movf));
`ifdef RV_IRET_TRACE_DROP_CNT_EN
    chk("m_drop_cnt", 64'(bus.drop_cnt), 64'(mdc));
`endif
    if (mq.size() != 0) begin
      chk("m_addr", 64'(bus.out_addr), 64'(mq[0].addr));
      chk("m_insn", 64'(bus.out_insn), 64'(mq[0].insn));
      chk("m_ires", 64'(bus.out_ires), 64'(mq[0].ires));
      chk("m_fres", 64'(bus.out_fres), 64'(mq[0].fres));
      chk("m_seq", 64'(bus.out_seq), 64'(mq[0].seq));
    end
  endtask

  // Advance one clock: update the model from the inputs present before the edge, then compare.
  task automatic tick();
    int n;
    int k;
    bit pop;
    trace_entry_t e;
    n = $countones(bus.in_iret);
    pop = (mq.size() != 0) && bus.out_ready;
    if (bus.flush) begin
      mq.delete();
      movf = 1'b0;
      mdc  = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (n <= DEPTH - mq.size()) begin
        k = 0;
        for (int c = 0; c < NRET; c++) begin
          if (bus.in_iret[c]) begin
            e.addr = bus.in_addr[c*32 +: 32];
            e.insn = bus.in_insn[c*32 +: 32];
            e.ires = bus.in_ires[c*32 +: 32];
            e.fres = bus.in_fres[c*32 +: 32];
            e.seq  = mseq + 32'(k);
            mq.push_back(e);
            k++;
          end
        end
      end else begin
        movf = 1'b1;
        mdc  = (mdc + n > 65535) ? 65535 : mdc + n;
      end
    end
    mseq = mseq + 32'(n);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic set_data(input int k);
    for (int c = 0; c < NRET; c++) begin
      bus.in_addr[c*32 +: 32] = 32'h100 + 32'(8 * k) + 32'(4 * c);
      bus.in_insn[c*32 +: 32] = $urandom;
      bus.in_ires[c*32 +: 32] = $urandom;
      bus.in_fres[c*32 +: 32] = $urandom;
    end
  endtask

  typedef struct {
    logic [1:0]  iret;
    logic        ready;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [31:0] exp_seq;
  } vec_t;

  vec_t tbl[4];
  logic [31:0] seen[$];

  initial begin
    tbl[0] = '{iret: 2'b11, ready: 1'b1, exp_valid: 1'b1, exp_addr: 32'h100, exp_seq: 32'd0};
    tbl[1] = '{iret: 2'b00, ready: 1'b1, exp_valid: 1'b1, exp_addr: 32'h104, exp_seq: 32'd1};
    tbl[2] = '{iret: 2'b10, ready: 1'b1, exp_valid: 1'b1, exp_addr: 32'h114, exp_seq: 32'd2};
    tbl[3] = '{iret: 2'b00, ready: 1'b1, exp_valid: 1'b0, exp_addr: 32'h0,   exp_seq: 32'd0};

    bus.flush = 1'b0;
    bus.in_iret = '0;
    bus.out_ready = 1'b0;
    set_data(0);
    model_reset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    rst = 1'b0;
    tick();

    // Directed table: pair retire, lone channel 1 retire, drain to empty
    for (int k = 0; k < 4; k++) begin
      bus.in_iret = tbl[k].iret;
      bus.out_ready = tbl[k].ready;
      set_data(k);
      tick();
      chk("tbl_valid", 64'(bus.out_valid), 64'(tbl[k].exp_valid));
      if (tbl[k].exp_valid) begin
        chk("tbl_addr", 64'(bus.out_addr), 64'(tbl[k].exp_addr));
        chk("tbl_seq", 64'(bus.out_seq), 64'(tbl[k].exp_seq));
      end
    end

    // Reset mid-operation clears immediately; nothing appears on release
    bus.in_iret = 2'b11;
    bus.out_ready = 1'b0;
    set_data(9);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_full", 64'(bus.full), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.in_iret = 2'b00;
    tick();
    chk("release_valid", 64'(bus.out_valid), 64'd0);

    // Fill to full, then drop a group
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.in_iret = 2'b11;
      set_data(20 + k);
      tick();
    end
    chk("fill_full", 64'(bus.full), 64'd1);
    chk("fill_ovf", 64'(bus.ovf), 64'd0);
    set_data(28);
    tick();
    chk("drop_ovf", 64'(bus.ovf), 64'd1);
    chk("drop_full", 64'(bus.full), 64'd1);
`ifdef RV_IRET_TRACE_DROP_CNT_EN
    chk("drop_cnt2", 64'(bus.drop_cnt), 64'd2);
`endif

    // Full with simultaneous pop and single push
    bus.out_ready = 1'b1;
    bus.in_iret = 2'b01;
    set_data(29);
    tick();
    chk("fullpush_full", 64'(bus.full), 64'd1);
    chk("fullpush_head", 64'(bus.out_seq), 64'd1);
`ifdef RV_IRET_TRACE_DROP_CNT_EN
    chk("fullpush_dcnt", 64'(bus.drop_cnt), 64'd2);
`endif

    // Drain and look for the sequence gap left by the dropped group
    bus.in_iret = 2'b00;
    seen.delete();
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) seen.push_back(bus.out_seq);
      tick();
    end
    chk("drain_cnt", 64'(seen.size()), 64'd16);
    if (seen.size() >= 16) begin
      chk("gap_lo", 64'(seen[14]), 64'd15);
      chk("gap_hi", 64'(seen[15]), 64'd18);
    end
    chk("drain_empty", 64'(bus.out_valid), 64'd0);

    // Flush with 5 entries and a concurrent 2-record push (seq_cnt 24 before flush)
    bus.out_ready = 1'b0;
    bus.in_iret = 2'b11; set_data(30); tick();
    bus.in_iret = 2'b11; set_data(31); tick();
    bus.in_iret = 2'b01; set_data(32); tick();
    chk("pre_flush_head", 64'(bus.out_seq), 64'd19);
    bus.flush = 1'b1;
    bus.in_iret = 2'b11;
    set_data(33);
    tick();
    bus.flush = 1'b0;
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_ovf", 64'(bus.ovf), 64'd0);
`ifdef RV_IRET_TRACE_DROP_CNT_EN
    chk("flush_dcnt", 64'(bus.drop_cnt), 64'd0);
`endif
    bus.in_iret = 2'b01;
    set_data(34);
    tick();
    chk("post_flush_seq", 64'(bus.out_seq), 64'd26);
    chk("post_flush_addr", 64'(bus.out_addr), 64'(32'h100 + 32'(8 * 34)));

    // Random traffic with alternating backpressure phases
    for (int i = 0; i < 600; i++) begin
      bus.in_iret = 2'($urandom);
      bus.out_ready = (((i / 50) % 2) != 0) ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 85);
      bus.flush = ($urandom_range(0, 63) == 0);
      for (int c = 0; c < NRET; c++) begin
        bus.in_addr[c*32 +: 32] = $urandom;
        bus.in_insn[c*32 +: 32] = $urandom;
        bus.in_ires[c*32 +: 32] = $urandom;
        bus.in_fres[c*32 +: 32] = $urandom;
      end
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
